led_pwm_fader: RTL and testbench

- Downstream consumer of the 3-bit LED pattern produced by the LED blink counter.
- Turns each pattern bit into a PWM-driven RGB LED channel. Each channel ramps smoothly between off and full brightness instead of snapping.
- Drives the board RGB LED pins directly. Exposes a busy flag and per-channel brightness levels for debug and verification.

---
 rtl/led_pwm_fader.sv | 118 +++++++++++
 tb/tb_led_pwm_fader.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_fader.sv
// Three-channel RGB LED driver: each pattern bit fades its channel between off
// and full brightness one step per tick, and each level is rendered as PWM.
module led_pwm_fader #(
    parameter int PWM_BITS   = 8,
    parameter int TICK_DIV   = 4096,
    parameter int MAX_LEVEL  = 255,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              code_in,
    output logic [2:0]              pwm_out,
    output logic                    busy,
    output logic [3*PWM_BITS-1:0]   level_out
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [PWM_BITS-1:0] MAX_LVL   = PWM_BITS'(MAX_LEVEL);
    localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'((1 << PWM_BITS) - 2);
    localparam logic                POL       = (ACTIVE_LOW != 0);

    typedef enum logic {
        IDLE,
        FADING
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [2:0]          code_q;
    logic [PWM_BITS-1:0] level      [3];
    logic [PWM_BITS-1:0] level_next [3];
    logic [PWM_BITS-1:0] target     [3];
    logic [TICK_W-1:0]   tick_cnt;
    logic [TICK_W-1:0]   tick_next;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                any_diff;
    logic                settled;

    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        any_diff   = 1'b0;
        settled    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            target[i]     = code_q[i] ? MAX_LVL : '0;
            level_next[i] = level[i];
            if (level[i] != target[i]) begin
                any_diff = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                tick_next = '0;
                if (any_diff) begin
                    state_next = FADING;
                end
            end
            FADING: begin
                // Targets are re-read on every tick, so a changed code simply
                // redirects each channel from wherever it currently sits.
                if (tick_cnt == TICK_LAST) begin
                    tick_next = '0;
                    for (int i = 0; i < 3; i++) begin
                        if (level[i] < target[i]) begin
                            level_next[i] = level[i] + PWM_BITS'(1);
                        end else if (level[i] > target[i]) begin
                            level_next[i] = level[i] - PWM_BITS'(1);
                        end
                        if (level_next[i] != target[i]) begin
                            settled = 1'b0;
                        end
                    end
                    if (settled) begin
                        state_next = IDLE;
                    end
                end else begin
                    tick_next = tick_cnt + TICK_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q   <= 3'b000;
            state    <= IDLE;
            tick_cnt <= '0;
            pwm_cnt  <= '0;
            pwm_out  <= {3{POL}};
            for (int i = 0; i < 3; i++) begin
                level[i] <= '0;
            end
        end else begin
            code_q   <= code_in;
            state    <= state_next;
            tick_cnt <= tick_next;
            // The PWM period skips the all-ones count so a full-scale level stays solidly on.
            pwm_cnt  <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PWM_BITS'(1);
            for (int i = 0; i < 3; i++) begin
                level[i]   <= level_next[i];
                pwm_out[i] <= (pwm_cnt < level[i]) ^ POL;
            end
        end
    end

    assign busy = (state == FADING);

    always_comb begin
        level_out = '0;
        for (int i = 0; i < 3; i++) begin
            level_out[i*PWM_BITS +: PWM_BITS] = level[i];
        end
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader: scenario tasks plus a randomized run against a
// cycle-level behavioural model of the fader.
module tb_led_pwm_fader;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  code_a;
    logic [2:0]  code_b;
    logic [2:0]  pwm_a;
    logic [2:0]  pwm_b;
    logic        busy_a;
    logic        busy_b;
    logic [23:0] lvl_a;
    logic [23:0] lvl_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Main instance: full-scale 255, common-anode pins.
    led_pwm_fader #(.PWM_BITS(8), .TICK_DIV(TD), .MAX_LEVEL(255), .ACTIVE_LOW(1)) dut_a (
        .clk(clk), .rst(rst), .code_in(code_a),
        .pwm_out(pwm_a), .busy(busy_a), .level_out(lvl_a)
    );

    // Second instance settles at level 64 with active-high pins, for duty checks.
    led_pwm_fader #(.PWM_BITS(8), .TICK_DIV(TD), .MAX_LEVEL(64), .ACTIVE_LOW(0)) dut_b (
        .clk(clk), .rst(rst), .code_in(code_b),
        .pwm_out(pwm_b), .busy(busy_b), .level_out(lvl_b)
    );

    function automatic int chan(input logic [23:0] v, input int ch);
        return int'(v[ch*8 +: 8]);
    endfunction

    // Behavioural model of dut_a: fading runs on a global "cycles since the
    // fade began" count, and every TD-th cycle moves levels one step.
    int         m_level [3] = '{0, 0, 0};
    int         m_elapsed = 0;
    int         m_pwm_cnt = 0;
    logic [2:0] m_code_q = 3'b000;
    logic [2:0] m_pwm = 3'b111;
    bit         m_busy = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_code_q  = 3'b000;
            m_level   = '{0, 0, 0};
            m_busy    = 1'b0;
            m_elapsed = 0;
            m_pwm_cnt = 0;
            m_pwm     = 3'b111;
        end else begin
            bit differ;
            for (int i = 0; i < 3; i++) m_pwm[i] = !(m_pwm_cnt < m_level[i]);
            m_pwm_cnt = (m_pwm_cnt + 1) % 255;
            differ = 1'b0;
            for (int i = 0; i < 3; i++)
                if (m_level[i] != (m_code_q[i] ? 255 : 0)) differ = 1'b1;
            if (!m_busy) begin
                if (differ) begin
                    m_busy    = 1'b1;
                    m_elapsed = 0;
                end
            end else begin
                m_elapsed++;
                if (m_elapsed % TD == 0) begin
                    differ = 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        int tgt;
                        tgt = m_code_q[i] ? 255 : 0;
                        if (m_level[i] < tgt) m_level[i]++;
                        else if (m_level[i] > tgt) m_level[i]--;
                        if (m_level[i] != tgt) differ = 1'b1;
                    end
                    if (!differ) m_busy = 1'b0;
                end
            end
            m_code_q = code_a;
        end
    end

    task automatic wait_idle_a();
        bit done;
        done = 1'b0;
        repeat (3) @(negedge clk);
        for (int c = 0; c < 3000 && !done; c++) begin
            if (!busy_a) done = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL wait_idle: busy stuck at %0b, required 0", busy_a);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        code_a = 3'b111;
        code_b = 3'b111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (lvl_a !== 24'd0 || busy_a !== 1'b0 || pwm_a !== 3'b111) begin
                errors++;
                $display("[TB] FAIL reset_hold: level=%h busy=%b pwm=%b, required 000000 0 111",
                         lvl_a, busy_a, pwm_a);
            end
        end
        checks++;
        if (pwm_b !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_pwm_active_high: pwm=%b, required 000", pwm_b);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (lvl_a !== 24'd0 || busy_a !== 1'b0 || pwm_a !== 3'b111) begin
            errors++;
            $display("[TB] FAIL reset_after: level=%h busy=%b pwm=%b, required 000000 0 111",
                     lvl_a, busy_a, pwm_a);
        end
        code_a = 3'b000;
        code_b = 3'b010;
        wait_idle_a();
    endtask

    task automatic test_ramp_up();
        int n;
        logic [23:0] exp;
        code_a = 3'b001;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ramp_busy_t1: busy=%b, required 0", busy_a);
        end
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ramp_busy_t2: busy=%b, required 1", busy_a);
        end
        n = 0;
        while (busy_a === 1'b1 && n < 2000 && errors < 50) begin
            exp = {8'd0, 8'd0, 8'(n / TD)};
            checks++;
            if (lvl_a !== exp) begin
                errors++;
                $display("[TB] FAIL ramp_level n=%0d: level=%h, required %h", n, lvl_a, exp);
            end
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 255 * TD) begin
            errors++;
            $display("[TB] FAIL ramp_busy_cycles: got %0d, required %0d", n, 255 * TD);
        end
        checks++;
        if (lvl_a !== {8'd0, 8'd0, 8'd255}) begin
            errors++;
            $display("[TB] FAIL ramp_final: level=%h, required 0000ff", lvl_a);
        end
    endtask

    task automatic test_pwm_duty();
        int hi_b1, hi_b0, hi_a0, hi_a1;
        checks++;
        if (busy_b !== 1'b0 || chan(lvl_b, 1) != 64) begin
            errors++;
            $display("[TB] FAIL duty_setup: busy=%b level1=%0d, required 0 64", busy_b, chan(lvl_b, 1));
        end
        for (int p = 0; p < 3; p++) begin
            hi_b1 = 0; hi_b0 = 0; hi_a0 = 0; hi_a1 = 0;
            repeat (255) begin
                @(negedge clk);
                hi_b1 += int'(pwm_b[1]);
                hi_b0 += int'(pwm_b[0]);
                hi_a0 += int'(pwm_a[0]);
                hi_a1 += int'(pwm_a[1]);
            end
            checks++;
            if (hi_b1 != 64) begin
                errors++;
                $display("[TB] FAIL duty_64 period %0d: high=%0d, required 64", p, hi_b1);
            end
            checks++;
            if (hi_b0 != 0) begin
                errors++;
                $display("[TB] FAIL duty_0 period %0d: high=%0d, required 0", p, hi_b0);
            end
            checks++;
            if (hi_a0 != 0 || hi_a1 != 255) begin
                errors++;
                $display("[TB] FAIL duty_full_lowpin period %0d: pin0 high=%0d pin1 high=%0d, required 0 255",
                         p, hi_a0, hi_a1);
            end
        end
    endtask

    task automatic test_reversal();
        int  busy_cnt, maxl;
        bit  rose, switched;
        busy_cnt = 0; maxl = 0; rose = 1'b0; switched = 1'b0;
        code_a = 3'b101;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (busy_a) begin
                busy_cnt++;
                rose = 1'b1;
            end else if (rose) begin
                break;
            end
            if (chan(lvl_a, 2) > maxl) maxl = chan(lvl_a, 2);
            if (!switched && chan(lvl_a, 2) == 100) begin
                code_a   = 3'b001;
                switched = 1'b1;
            end
        end
        checks++;
        if (!switched || maxl > 101) begin
            errors++;
            $display("[TB] FAIL reversal_peak: peak=%0d switched=%0b, required <=101 1", maxl, switched);
        end
        checks++;
        if (busy_cnt < 199 * TD || busy_cnt > 201 * TD) begin
            errors++;
            $display("[TB] FAIL reversal_busy: got %0d cycles, required %0d..%0d", busy_cnt, 199 * TD, 201 * TD);
        end
        checks++;
        if (lvl_a !== {8'd0, 8'd0, 8'd255}) begin
            errors++;
            $display("[TB] FAIL reversal_final: level=%h, required 0000ff", lvl_a);
        end
    endtask

    task automatic test_crossfade();
        bit rose, settled;
        int l0, l1, l2;
        rose = 1'b0;
        code_a = 3'b110;
        for (int c = 0; c < 3000 && errors < 50; c++) begin
            @(negedge clk);
            l0 = chan(lvl_a, 0); l1 = chan(lvl_a, 1); l2 = chan(lvl_a, 2);
            checks++;
            if (l1 != l2 || l0 != 255 - l1) begin
                errors++;
                $display("[TB] FAIL crossfade_lockstep: levels %0d/%0d/%0d, required ch1==ch2==255-ch0",
                         l0, l1, l2);
            end
            if (busy_a) rose = 1'b1;
            if (rose) begin
                settled = (l0 == 0 && l1 == 255 && l2 == 255);
                checks++;
                if (busy_a !== !settled) begin
                    errors++;
                    $display("[TB] FAIL crossfade_busy: busy=%b settled=%0b, required busy=!settled",
                             busy_a, settled);
                end
                if (!busy_a) break;
            end
        end
        checks++;
        if (!rose || lvl_a !== {8'd255, 8'd255, 8'd0}) begin
            errors++;
            $display("[TB] FAIL crossfade_final: level=%h rose=%0b, required ffff00 1", lvl_a, rose);
        end
    endtask

    task automatic test_reset_midfade();
        bit hit;
        hit = 1'b0;
        code_a = 3'b001;
        for (int c = 0; c < 3000 && !hit; c++) begin
            @(negedge clk);
            if (chan(lvl_a, 0) == 50) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("[TB] FAIL midfade_reach50: level0=%0d, required 50", chan(lvl_a, 0));
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (lvl_a !== 24'd0 || busy_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midfade_abort: level=%h busy=%b, required 000000 0", lvl_a, busy_a);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midfade_restart_t1: busy=%b, required 0", busy_a);
        end
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b1 || lvl_a !== 24'd0) begin
            errors++;
            $display("[TB] FAIL midfade_restart_t2: busy=%b level=%h, required 1 000000", busy_a, lvl_a);
        end
        repeat (TD) @(negedge clk);
        checks++;
        if (lvl_a !== {8'd0, 8'd0, 8'd1}) begin
            errors++;
            $display("[TB] FAIL midfade_first_step: level=%h, required 000001", lvl_a);
        end
    endtask

    task automatic test_random();
        logic [23:0] exp;
        for (int t = 0; t < 150 && errors < 50; t++) begin
            int hold;
            code_a = 3'($urandom_range(0, 7));
            hold   = int'($urandom_range(1, 60));
            rst    = ($urandom_range(0, 39) == 0);
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                rst = 1'b0;
                exp = {8'(m_level[2]), 8'(m_level[1]), 8'(m_level[0])};
                checks++;
                if (lvl_a !== exp || busy_a !== m_busy || pwm_a !== m_pwm) begin
                    errors++;
                    $display("[TB] FAIL random t=%0d: level=%h busy=%b pwm=%b, required %h %b %b",
                             t, lvl_a, busy_a, pwm_a, exp, m_busy, m_pwm);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        code_a = 3'b000;
        code_b = 3'b000;
        test_reset();
        test_ramp_up();
        test_pwm_duty();
        test_reversal();
        test_crossfade();
        test_reset_midfade();
        wait_idle_a();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
